// File: rtl/control_sequencer.sv
// Multi-cycle fetch/decode/execute control unit for the 32-bit bus CPU.
// Strobes are Moore outputs of the state, latched opcode and wait counter.
module control_sequencer #(
    parameter int MEM_WAIT   = 1,
    parameter int MULDIV_EXT = 2
) (
    input  logic        clk,
    input  logic        clear,
    input  logic        stop,
    input  logic [31:0] IR,
    input  logic        CON_FF,
    output logic        run,
    output logic        PCout,
    output logic        MDRout,
    output logic        HIout,
    output logic        LOout,
    output logic        Zhighout,
    output logic        Zlowout,
    output logic        Inportout,
    output logic        Cout,
    output logic        PCin,
    output logic        IRin,
    output logic        MARin,
    output logic        MDRin,
    output logic        Yin,
    output logic        Zin,
    output logic        HIin,
    output logic        LOin,
    output logic        OutPort,
    output logic        CONin,
    output logic        Gra,
    output logic        Grb,
    output logic        Grc,
    output logic        Rin,
    output logic        Rout,
    output logic        BAout,
    output logic        read,
    output logic        write,
    output logic        AND,
    output logic        OR,
    output logic        ADD,
    output logic        SUB,
    output logic        MUL,
    output logic        DIV,
    output logic        SHR,
    output logic        SHL,
    output logic        ROR,
    output logic        ROL,
    output logic        NEG,
    output logic        NOT,
    output logic        IncPC
);

    localparam int B_PCOUT = 38, B_MDROUT = 37, B_HIOUT = 36, B_LOOUT = 35;
    localparam int B_ZHI = 34, B_ZLO = 33, B_INPORT = 32, B_COUT = 31;
    localparam int B_PCIN = 30, B_IRIN = 29, B_MARIN = 28, B_MDRIN = 27;
    localparam int B_YIN = 26, B_ZIN = 25, B_HIIN = 24, B_LOIN = 23;
    localparam int B_OUTP = 22, B_CONIN = 21, B_GRA = 20, B_GRB = 19;
    localparam int B_GRC = 18, B_RIN = 17, B_ROUT = 16, B_BAOUT = 15;
    localparam int B_READ = 14, B_WRITE = 13, B_AND = 12, B_OR = 11;
    localparam int B_ADD = 10, B_SUB = 9, B_MUL = 8, B_DIV = 7;
    localparam int B_SHR = 6, B_SHL = 5, B_ROR = 4, B_ROL = 3;
    localparam int B_NEG = 2, B_NOT = 1, B_INCPC = 0;

    localparam logic [2:0] MEM_CNT = 3'(MEM_WAIT);
    localparam logic [2:0] MD_CNT  = 3'(MULDIV_EXT);

    localparam logic [4:0] OP_LD   = 5'd0,  OP_LDI  = 5'd1,  OP_ST   = 5'd2;
    localparam logic [4:0] OP_ADD  = 5'd3,  OP_SUB  = 5'd4,  OP_AND  = 5'd5;
    localparam logic [4:0] OP_OR   = 5'd6,  OP_SHR  = 5'd7,  OP_SHL  = 5'd8;
    localparam logic [4:0] OP_ROR  = 5'd9,  OP_ROL  = 5'd10, OP_ADDI = 5'd11;
    localparam logic [4:0] OP_ANDI = 5'd12, OP_ORI  = 5'd13, OP_MUL  = 5'd14;
    localparam logic [4:0] OP_DIV  = 5'd15, OP_NEG  = 5'd16, OP_NOT  = 5'd17;
    localparam logic [4:0] OP_BR   = 5'd18, OP_JR   = 5'd19, OP_JAL  = 5'd20;
    localparam logic [4:0] OP_IN   = 5'd21, OP_OUT  = 5'd22, OP_MFHI = 5'd23;
    localparam logic [4:0] OP_MFLO = 5'd24, OP_HALT = 5'd26;

    typedef enum logic [5:0] {
        S_RESET, S_T0, S_T1, S_T2, S_HALT,
        S_ALU_Y, S_ALU_RC, S_ALU_C, S_ALU_UN, S_WB_Z,
        S_MD_Y, S_MD_OP, S_MD_LO, S_MD_HI,
        S_AD_Y, S_AD_Z, S_AD_MAR, S_LD_RD, S_LD_WB, S_ST_MDR, S_ST_WR,
        S_BR_CON, S_BR_Y, S_BR_Z, S_BR_TAKE, S_BR_SKIP,
        S_JAL, S_JR, S_IN, S_OUT, S_MFHI, S_MFLO, S_NOP
    } state_t;

    state_t      state;
    state_t      state_n;
    logic [2:0]  cnt;
    logic [2:0]  cnt_n;
    logic [4:0]  op;
    logic        stop_pend;
    logic        stop_pend_n;
    logic        last;
    logic        is_imm;
    logic        alu_go;
    logic [38:0] s;
    logic        unused_ir;

    assign unused_ir = ^IR[26:0];
    assign is_imm = (op == OP_ADDI) || (op == OP_ANDI) || (op == OP_ORI);

    assign {PCout, MDRout, HIout, LOout, Zhighout, Zlowout, Inportout, Cout,
            PCin, IRin, MARin, MDRin, Yin, Zin, HIin, LOin, OutPort, CONin,
            Gra, Grb, Grc, Rin, Rout, BAout, read, write,
            AND, OR, ADD, SUB, MUL, DIV, SHR, SHL, ROR, ROL, NEG, NOT,
            IncPC} = s;

    assign run = (state != S_RESET) && (state != S_HALT);

    // State, wait counter, latched opcode and pending-stop registers
    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            state     <= S_RESET;
            cnt       <= 3'd0;
            op        <= 5'd0;
            stop_pend <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            stop_pend <= stop_pend_n;
            if (state == S_T2) op <= IR[31:27];
        end
    end

    // Next-state sequencing; held steps count down before advancing
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        last    = 1'b0;
        unique case (state)
            S_RESET: state_n = S_T0;
            S_T0: begin
                state_n = S_T1;
                cnt_n   = MEM_CNT;
            end
            S_T1: begin
                if (cnt != 3'd0) cnt_n = cnt - 3'd1;
                else state_n = S_T2;
            end
            S_T2: begin
                case (IR[31:27])
                    OP_LD, OP_LDI, OP_ST: state_n = S_AD_Y;
                    OP_ADD, OP_SUB, OP_AND, OP_OR,
                    OP_SHR, OP_SHL, OP_ROR, OP_ROL,
                    OP_ADDI, OP_ANDI, OP_ORI: state_n = S_ALU_Y;
                    OP_MUL, OP_DIV: state_n = S_MD_Y;
                    OP_NEG, OP_NOT: state_n = S_ALU_UN;
                    OP_BR:   state_n = S_BR_CON;
                    OP_JR:   state_n = S_JR;
                    OP_JAL:  state_n = S_JAL;
                    OP_IN:   state_n = S_IN;
                    OP_OUT:  state_n = S_OUT;
                    OP_MFHI: state_n = S_MFHI;
                    OP_MFLO: state_n = S_MFLO;
                    OP_HALT: state_n = S_HALT;
                    default: state_n = S_NOP;
                endcase
            end
            S_HALT: state_n = S_HALT;
            S_ALU_Y: state_n = is_imm ? S_ALU_C : S_ALU_RC;
            S_ALU_RC, S_ALU_C, S_ALU_UN: state_n = S_WB_Z;
            S_MD_Y: begin
                state_n = S_MD_OP;
                cnt_n   = MD_CNT;
            end
            S_MD_OP: begin
                if (cnt != 3'd0) cnt_n = cnt - 3'd1;
                else state_n = S_MD_LO;
            end
            S_MD_LO: state_n = S_MD_HI;
            S_AD_Y: state_n = S_AD_Z;
            S_AD_Z: state_n = (op == OP_LDI) ? S_WB_Z : S_AD_MAR;
            S_AD_MAR: begin
                if (op == OP_LD) begin
                    state_n = S_LD_RD;
                    cnt_n   = MEM_CNT;
                end else begin
                    state_n = S_ST_MDR;
                end
            end
            S_LD_RD: begin
                if (cnt != 3'd0) cnt_n = cnt - 3'd1;
                else state_n = S_LD_WB;
            end
            S_ST_MDR: begin
                state_n = S_ST_WR;
                cnt_n   = MEM_CNT;
            end
            S_ST_WR: begin
                if (cnt != 3'd0) cnt_n = cnt - 3'd1;
                else last = 1'b1;
            end
            S_BR_CON: state_n = S_BR_Y;
            S_BR_Y:   state_n = S_BR_Z;
            S_BR_Z:   state_n = CON_FF ? S_BR_TAKE : S_BR_SKIP;
            S_JAL:    state_n = S_JR;
            S_WB_Z, S_MD_HI, S_LD_WB, S_BR_TAKE, S_BR_SKIP,
            S_JR, S_IN, S_OUT, S_MFHI, S_MFLO, S_NOP: last = 1'b1;
            default: state_n = S_RESET;
        endcase
        if (last) state_n = (stop || stop_pend) ? S_HALT : S_T0;
    end

    // A stop seen at any edge of an instruction is held until it retires
    always_comb begin
        stop_pend_n = stop_pend | stop;
        if (state == S_RESET || state == S_HALT || last) stop_pend_n = 1'b0;
    end

    // Strobe decode from the current step and latched opcode
    always_comb begin
        s      = '0;
        alu_go = 1'b0;
        unique case (state)
            S_T0: begin
                s[B_PCOUT] = 1'b1; s[B_MARIN] = 1'b1;
                s[B_INCPC] = 1'b1; s[B_ZIN]   = 1'b1;
            end
            S_T1: begin
                s[B_ZLO]  = 1'b1; s[B_PCIN]  = 1'b1;
                s[B_READ] = 1'b1; s[B_MDRIN] = 1'b1;
            end
            S_T2: begin
                s[B_MDROUT] = 1'b1; s[B_IRIN] = 1'b1;
            end
            S_ALU_Y: begin
                s[B_GRB] = 1'b1; s[B_ROUT] = 1'b1; s[B_YIN] = 1'b1;
            end
            S_ALU_RC: begin
                s[B_GRC] = 1'b1; s[B_ROUT] = 1'b1; s[B_ZIN] = 1'b1;
                alu_go = 1'b1;
            end
            S_ALU_C: begin
                s[B_COUT] = 1'b1; s[B_ZIN] = 1'b1;
                alu_go = 1'b1;
            end
            S_ALU_UN, S_MD_OP: begin
                s[B_GRB] = 1'b1; s[B_ROUT] = 1'b1; s[B_ZIN] = 1'b1;
                alu_go = 1'b1;
            end
            S_WB_Z: begin
                s[B_ZLO] = 1'b1; s[B_GRA] = 1'b1; s[B_RIN] = 1'b1;
            end
            S_MD_Y: begin
                s[B_GRA] = 1'b1; s[B_ROUT] = 1'b1; s[B_YIN] = 1'b1;
            end
            S_MD_LO: begin
                s[B_ZLO] = 1'b1; s[B_LOIN] = 1'b1;
            end
            S_MD_HI: begin
                s[B_ZHI] = 1'b1; s[B_HIIN] = 1'b1;
            end
            S_AD_Y: begin
                s[B_GRB] = 1'b1; s[B_BAOUT] = 1'b1; s[B_YIN] = 1'b1;
            end
            S_AD_Z, S_BR_Z: begin
                s[B_COUT] = 1'b1; s[B_ADD] = 1'b1; s[B_ZIN] = 1'b1;
            end
            S_AD_MAR: begin
                s[B_ZLO] = 1'b1; s[B_MARIN] = 1'b1;
            end
            S_LD_RD: begin
                s[B_READ] = 1'b1; s[B_MDRIN] = 1'b1;
            end
            S_LD_WB: begin
                s[B_MDROUT] = 1'b1; s[B_GRA] = 1'b1; s[B_RIN] = 1'b1;
            end
            S_ST_MDR: begin
                s[B_GRA] = 1'b1; s[B_ROUT] = 1'b1; s[B_MDRIN] = 1'b1;
            end
            S_ST_WR: s[B_WRITE] = 1'b1;
            S_BR_CON: begin
                s[B_GRA] = 1'b1; s[B_ROUT] = 1'b1; s[B_CONIN] = 1'b1;
            end
            S_BR_Y: begin
                s[B_PCOUT] = 1'b1; s[B_YIN] = 1'b1;
            end
            S_BR_TAKE: begin
                s[B_ZLO] = 1'b1; s[B_PCIN] = 1'b1;
            end
            S_JAL: begin
                s[B_PCOUT] = 1'b1; s[B_GRB] = 1'b1; s[B_RIN] = 1'b1;
            end
            S_JR: begin
                s[B_GRA] = 1'b1; s[B_ROUT] = 1'b1; s[B_PCIN] = 1'b1;
            end
            S_IN: begin
                s[B_INPORT] = 1'b1; s[B_GRA] = 1'b1; s[B_RIN] = 1'b1;
            end
            S_OUT: begin
                s[B_GRA] = 1'b1; s[B_ROUT] = 1'b1; s[B_OUTP] = 1'b1;
            end
            S_MFHI: begin
                s[B_HIOUT] = 1'b1; s[B_GRA] = 1'b1; s[B_RIN] = 1'b1;
            end
            S_MFLO: begin
                s[B_LOOUT] = 1'b1; s[B_GRA] = 1'b1; s[B_RIN] = 1'b1;
            end
            default: ;
        endcase
        if (alu_go) begin
            case (op)
                OP_ADD, OP_ADDI: s[B_ADD] = 1'b1;
                OP_AND, OP_ANDI: s[B_AND] = 1'b1;
                OP_OR, OP_ORI:   s[B_OR]  = 1'b1;
                OP_SUB: s[B_SUB] = 1'b1;
                OP_SHR: s[B_SHR] = 1'b1;
                OP_SHL: s[B_SHL] = 1'b1;
                OP_ROR: s[B_ROR] = 1'b1;
                OP_ROL: s[B_ROL] = 1'b1;
                OP_MUL: s[B_MUL] = 1'b1;
                OP_DIV: s[B_DIV] = 1'b1;
                OP_NEG: s[B_NEG] = 1'b1;
                OP_NOT: s[B_NOT] = 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: fetch, ALU, branch, mul,
// reset mid-instruction, stop during st, and the halt opcode.
module tb_control_sequencer;

    logic        clk = 1'b0;
    logic        clear;
    logic        stop;
    logic [31:0] IR;
    logic        CON_FF;
    logic        run;
    logic PCout, MDRout, HIout, LOout, Zhighout, Zlowout, Inportout, Cout;
    logic PCin, IRin, MARin, MDRin, Yin, Zin, HIin, LOin, OutPort, CONin;
    logic Gra, Grb, Grc, Rin, Rout, BAout, read, write;
    logic AND, OR, ADD, SUB, MUL, DIV, SHR, SHL, ROR, ROL, NEG, NOT, IncPC;

    int checks = 0;
    int errors = 0;

    localparam logic [38:0] M_PCOUT  = 39'd1 << 38;
    localparam logic [38:0] M_MDROUT = 39'd1 << 37;
    localparam logic [38:0] M_ZHI    = 39'd1 << 34;
    localparam logic [38:0] M_ZLO    = 39'd1 << 33;
    localparam logic [38:0] M_COUT   = 39'd1 << 31;
    localparam logic [38:0] M_PCIN   = 39'd1 << 30;
    localparam logic [38:0] M_IRIN   = 39'd1 << 29;
    localparam logic [38:0] M_MARIN  = 39'd1 << 28;
    localparam logic [38:0] M_MDRIN  = 39'd1 << 27;
    localparam logic [38:0] M_YIN    = 39'd1 << 26;
    localparam logic [38:0] M_ZIN    = 39'd1 << 25;
    localparam logic [38:0] M_HIIN   = 39'd1 << 24;
    localparam logic [38:0] M_LOIN   = 39'd1 << 23;
    localparam logic [38:0] M_CONIN  = 39'd1 << 21;
    localparam logic [38:0] M_GRA    = 39'd1 << 20;
    localparam logic [38:0] M_GRB    = 39'd1 << 19;
    localparam logic [38:0] M_GRC    = 39'd1 << 18;
    localparam logic [38:0] M_RIN    = 39'd1 << 17;
    localparam logic [38:0] M_ROUT   = 39'd1 << 16;
    localparam logic [38:0] M_BAOUT  = 39'd1 << 15;
    localparam logic [38:0] M_READ   = 39'd1 << 14;
    localparam logic [38:0] M_WRITE  = 39'd1 << 13;
    localparam logic [38:0] M_ADD    = 39'd1 << 10;
    localparam logic [38:0] M_MUL    = 39'd1 << 8;
    localparam logic [38:0] M_INCPC  = 39'd1 << 0;
    localparam logic [38:0] NONE     = 39'd0;

    localparam logic [38:0] F0 = M_PCOUT | M_MARIN | M_INCPC | M_ZIN;
    localparam logic [38:0] F1 = M_ZLO | M_PCIN | M_READ | M_MDRIN;
    localparam logic [38:0] F2 = M_MDROUT | M_IRIN;

    logic [38:0] strb;
    assign strb = {PCout, MDRout, HIout, LOout, Zhighout, Zlowout, Inportout,
                   Cout, PCin, IRin, MARin, MDRin, Yin, Zin, HIin, LOin,
                   OutPort, CONin, Gra, Grb, Grc, Rin, Rout, BAout, read,
                   write, AND, OR, ADD, SUB, MUL, DIV, SHR, SHL, ROR, ROL,
                   NEG, NOT, IncPC};

    control_sequencer #(.MEM_WAIT(1), .MULDIV_EXT(2)) dut (
        .clk(clk), .clear(clear), .stop(stop), .IR(IR), .CON_FF(CON_FF),
        .run(run),
        .PCout(PCout), .MDRout(MDRout), .HIout(HIout), .LOout(LOout),
        .Zhighout(Zhighout), .Zlowout(Zlowout), .Inportout(Inportout),
        .Cout(Cout), .PCin(PCin), .IRin(IRin), .MARin(MARin),
        .MDRin(MDRin), .Yin(Yin), .Zin(Zin), .HIin(HIin), .LOin(LOin),
        .OutPort(OutPort), .CONin(CONin), .Gra(Gra), .Grb(Grb), .Grc(Grc),
        .Rin(Rin), .Rout(Rout), .BAout(BAout), .read(read), .write(write),
        .AND(AND), .OR(OR), .ADD(ADD), .SUB(SUB), .MUL(MUL), .DIV(DIV),
        .SHR(SHR), .SHL(SHL), .ROR(ROR), .ROL(ROL), .NEG(NEG), .NOT(NOT),
        .IncPC(IncPC)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [38:0] exp,
                       input logic exp_run);
        logic [7:0] drv;
        logic       one_drv;
        checks++;
        assert (strb === exp) else begin
            errors++;
            $error("FAIL %s strobes observed %h expected %h", tag, strb, exp);
        end
        checks++;
        assert (run === exp_run) else begin
            errors++;
            $error("FAIL %s run observed %b expected %b", tag, run, exp_run);
        end
        drv = strb[38:31];
        one_drv = ((drv & (drv - 8'd1)) == 8'd0);
        checks++;
        assert (one_drv === 1'b1) else begin
            errors++;
            $error("FAIL %s bus drivers observed %b expected at most one",
                   tag, drv);
        end
    endtask

    task automatic cyc(input string tag, input logic [38:0] exp,
                       input logic exp_run);
        @(negedge clk);
        chk(tag, exp, exp_run);
    endtask

    task automatic fetch(input string tag);
        cyc({tag, "_t0"}, F0, 1'b1);
        cyc({tag, "_t1a"}, F1, 1'b1);
        cyc({tag, "_t1b"}, F1, 1'b1);
        cyc({tag, "_t2"}, F2, 1'b1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        clear  = 1'b0;
        stop   = 1'b0;
        CON_FF = 1'b0;
        IR     = 32'h1844_0000;
        repeat (2) @(negedge clk);
        chk("reset", NONE, 1'b0);
        clear = 1'b1;

        // add R1,R2,R3
        fetch("add");
        cyc("add_e1", M_GRB | M_ROUT | M_YIN, 1'b1);
        cyc("add_e2", M_GRC | M_ROUT | M_ADD | M_ZIN, 1'b1);
        cyc("add_e3", M_ZLO | M_GRA | M_RIN, 1'b1);
        IR = 32'h9000_0014;

        // br not taken
        fetch("brn");
        cyc("brn_e1", M_GRA | M_ROUT | M_CONIN, 1'b1);
        cyc("brn_e2", M_PCOUT | M_YIN, 1'b1);
        cyc("brn_e3", M_COUT | M_ADD | M_ZIN, 1'b1);
        cyc("brn_e4", NONE, 1'b1);
        CON_FF = 1'b1;

        // br taken
        fetch("brt");
        cyc("brt_e1", M_GRA | M_ROUT | M_CONIN, 1'b1);
        cyc("brt_e2", M_PCOUT | M_YIN, 1'b1);
        cyc("brt_e3", M_COUT | M_ADD | M_ZIN, 1'b1);
        cyc("brt_e4", M_ZLO | M_PCIN, 1'b1);
        CON_FF = 1'b0;
        IR = 32'h7000_0000;

        // mul: Zin held three cycles
        fetch("mul");
        cyc("mul_e1", M_GRA | M_ROUT | M_YIN, 1'b1);
        cyc("mul_z1", M_GRB | M_ROUT | M_MUL | M_ZIN, 1'b1);
        cyc("mul_z2", M_GRB | M_ROUT | M_MUL | M_ZIN, 1'b1);
        cyc("mul_z3", M_GRB | M_ROUT | M_MUL | M_ZIN, 1'b1);
        cyc("mul_lo", M_ZLO | M_LOIN, 1'b1);
        cyc("mul_hi", M_ZHI | M_HIIN, 1'b1);
        IR = 32'h0000_0000;

        // ld interrupted by clear in its read step
        fetch("ld");
        cyc("ld_e1", M_GRB | M_BAOUT | M_YIN, 1'b1);
        cyc("ld_e2", M_COUT | M_ADD | M_ZIN, 1'b1);
        cyc("ld_e3", M_ZLO | M_MARIN, 1'b1);
        cyc("ld_e4", M_READ | M_MDRIN, 1'b1);
        #1 clear = 1'b0;
        #1 chk("ld_clr_now", NONE, 1'b0);
        cyc("ld_clr_hold", NONE, 1'b0);
        IR = 32'h1000_0000;
        clear = 1'b1;

        // st with a one-edge stop pulse
        fetch("st");
        cyc("st_e1", M_GRB | M_BAOUT | M_YIN, 1'b1);
        stop = 1'b1;
        cyc("st_e2", M_COUT | M_ADD | M_ZIN, 1'b1);
        stop = 1'b0;
        cyc("st_e3", M_ZLO | M_MARIN, 1'b1);
        cyc("st_e4", M_GRA | M_ROUT | M_MDRIN, 1'b1);
        cyc("st_w1", M_WRITE, 1'b1);
        cyc("st_w2", M_WRITE, 1'b1);
        cyc("st_halt1", NONE, 1'b0);
        cyc("st_halt2", NONE, 1'b0);
        cyc("st_halt3", NONE, 1'b0);

        // halt opcode
        clear = 1'b0;
        cyc("halt_clr", NONE, 1'b0);
        IR = 32'hD000_0000;
        clear = 1'b1;
        fetch("hlt");
        for (int i = 0; i < 20; i++) cyc("hlt_idle", NONE, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
